// File: rtl/cim_mem_arbiter_if.sv
// Source-side request/grant/return bundle and memory-side command bundle of the CiM storage arbiter.
interface cim_mem_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16
);
  logic [NUM_SRC-1:0]        src_req;
  logic [NUM_SRC-1:0]        src_we;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*DATA_W-1:0] src_wdata;
  logic [NUM_SRC-1:0]        src_gnt;
  logic [NUM_SRC-1:0]        src_rvalid;
  logic [DATA_W-1:0]         src_rdata;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic [NUM_SRC-1:0]        starved;

  // arbiter view
  modport slave (
    input  src_req, src_we, src_addr, src_wdata, mem_rdata,
    output src_gnt, src_rvalid, src_rdata, mem_en, mem_we, mem_addr, mem_wdata, starved
  );

  // requesters plus memory view
  modport master (
    output src_req, src_we, src_addr, src_wdata, mem_rdata,
    input  src_gnt, src_rvalid, src_rdata, mem_en, mem_we, mem_addr, mem_wdata, starved
  );
endinterface

// File: rtl/cim_mem_arbiter.sv
// NUM_SRC-way arbiter for the single-port temp-result storage: fixed priority with starvation
// promotion or round robin; memory command registered one cycle after grant, read data tagged back after RD_LAT.
module cim_mem_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int RD_LAT       = 2,
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  cim_mem_arbiter_if.slave  io_bus
);
  localparam int         PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_prom;
  logic [NUM_SRC-1:0] w_gnt;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any;
  int                 w_cand;

  logic [PTR_W-1:0]   r_ptr;
  logic [3:0]         r_age [NUM_SRC];
  logic [NUM_SRC-1:0] r_starved;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [NUM_SRC-1:0] r_cmd_tag;
  logic [NUM_SRC-1:0] r_tag_pipe [RD_LAT];

  assign w_req  = io_bus.src_req;
  assign w_prom = w_req & r_starved;

  always_comb begin
    w_idx  = '0;
    w_any  = 1'b0;
    w_cand = 0;
    if (RR_MODE != 0) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        w_cand = int'(r_ptr) + k;
        if (w_cand >= NUM_SRC) w_cand = w_cand - NUM_SRC;
        if (!w_any && w_req[w_cand]) begin
          w_any = 1'b1;
          w_idx = PTR_W'(w_cand);
        end
      end
    end else begin
      // promoted requesters first, then plain lowest-index
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!w_any && w_prom[i]) begin
          w_any = 1'b1;
          w_idx = PTR_W'(i);
        end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!w_any && w_req[i]) begin
          w_any = 1'b1;
          w_idx = PTR_W'(i);
        end
      end
    end
  end

  assign w_gnt = (w_any && rst_n) ? (NUM_SRC'(1) << w_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_starved   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cmd_tag   <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_age[i] <= '0;
      for (int j = 0; j < RD_LAT; j++) r_tag_pipe[j] <= '0;
    end else begin
      r_mem_en  <= w_any;
      r_cmd_tag <= '0;
      if (w_any) begin
        r_mem_we    <= io_bus.src_we[w_idx];
        r_mem_addr  <= io_bus.src_addr[int'(w_idx)*ADDR_W +: ADDR_W];
        r_mem_wdata <= io_bus.src_wdata[int'(w_idx)*DATA_W +: DATA_W];
        if (!io_bus.src_we[w_idx]) r_cmd_tag <= w_gnt;
        if (RR_MODE != 0) r_ptr <= (int'(w_idx) == NUM_SRC-1) ? '0 : w_idx + PTR_W'(1);
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (RR_MODE == 0 && w_req[i] && !w_gnt[i]) begin
          r_age[i]     <= (r_age[i] == LIMIT) ? LIMIT : r_age[i] + 4'd1;
          r_starved[i] <= (r_age[i] >= LIMIT - 4'd1);
        end else begin
          r_age[i]     <= '0;
          r_starved[i] <= 1'b0;
        end
      end
      // tag line starts at the mem_en cycle so its tap lines up with mem_rdata
      r_tag_pipe[0] <= r_cmd_tag;
      for (int j = 1; j < RD_LAT; j++) r_tag_pipe[j] <= r_tag_pipe[j-1];
    end
  end

  assign io_bus.src_gnt    = w_gnt;
  assign io_bus.src_rvalid = r_tag_pipe[RD_LAT-1];
  assign io_bus.src_rdata  = io_bus.mem_rdata;
  assign io_bus.mem_en     = r_mem_en;
  assign io_bus.mem_we     = r_mem_we;
  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.mem_wdata  = r_mem_wdata;
  assign io_bus.starved    = r_starved;
endmodule
